// File: rtl/siso_layer_sched.sv
// Read-stream scheduler for the pipelined SISO row unit.
// Issues each layer's addresses, waits for its writebacks, and counts iterations.
module siso_layer_sched #(
  parameter int LAYERS        = 2,
  parameter int ADDRWIDTH     = 5,
  parameter int ADDRDEPTH     = 20,
  parameter int ITERBITS      = 5,
  parameter int TOBITS        = 6,
  parameter int DRAIN_TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 early_stop,
  input  logic                 wren_in,
  input  logic                 wrlayer_in,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [ITERBITS-1:0]  iter_count
);

  localparam int WBW = $clog2(ADDRDEPTH + 1);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR  = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [WBW-1:0]       WB_FULL    = WBW'(ADDRDEPTH);
  localparam logic [TOBITS-1:0]    TO_LIMIT   = TOBITS'(DRAIN_TIMEOUT);
  localparam logic                 LAST_LAYER = 1'(LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                state;
  logic                  layer;
  logic [ADDRWIDTH-1:0]  addr;
  logic [WBW-1:0]        wb_cnt;
  logic [TOBITS-1:0]     wdog;
  logic [ITERBITS-1:0]   lim;

  logic                  wb_hit;
  logic [WBW-1:0]        wb_next;
  logic [TOBITS-1:0]     wdog_next;
  logic [ITERBITS-1:0]   iter_next;

  // Only writebacks of the layer being worked on retire it.
  assign wb_hit    = wren_in && (wrlayer_in == layer);
  assign wb_next   = wb_cnt + WBW'(wb_hit);
  assign wdog_next = wdog + TOBITS'(1);
  assign iter_next = iter_count + ITERBITS'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      layer       <= 1'b0;
      addr        <= '0;
      wb_cnt      <= '0;
      wdog        <= '0;
      lim         <= '0;
      rdlayer     <= 1'b0;
      rdaddress   <= '0;
      rden_LLR    <= 1'b0;
      rden_E      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      iter_count  <= '0;
    end else begin
      rden_LLR <= 1'b0;
      rden_E   <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            lim         <= (max_iter == '0) ? ITERBITS'(1) : max_iter;
            iter_count  <= '0;
            timeout_err <= 1'b0;
            layer       <= 1'b0;
            addr        <= '0;
            wb_cnt      <= '0;
            wdog        <= '0;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rden_LLR  <= 1'b1;
          // E memory is still empty during the first iteration.
          rden_E    <= (iter_count != '0);
          rdlayer   <= layer;
          rdaddress <= addr;
          addr      <= addr + ADDRWIDTH'(1);
          wb_cnt    <= wb_next;
          if (addr == LAST_ADDR) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          wb_cnt <= wb_next;
          wdog   <= wdog_next;
          if (wb_next == WB_FULL) begin
            if (layer != LAST_LAYER) begin
              layer  <= layer + 1'b1;
              addr   <= '0;
              wb_cnt <= '0;
              wdog   <= '0;
              state  <= S_ISSUE;
            end else begin
              state <= S_CHECK;
            end
          end else if (wdog_next == TO_LIMIT) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_CHECK: begin
          iter_count <= iter_next;
          if (early_stop || (iter_next == lim)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            layer  <= 1'b0;
            addr   <= '0;
            wb_cnt <= '0;
            wdog   <= '0;
            state  <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_layer_sched.sv
// Bench for siso_layer_sched: delayed-writeback row model and
// a read-stream reference built from layer/address/iteration arithmetic.
module tb_siso_layer_sched;

  localparam int LAYERS = 2;
  localparam int DEPTH  = 20;
  localparam int IB     = 5;
  localparam int DLY    = 13;
  localparam int TO     = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IB-1:0] max_iter = '0;
  logic          early_stop = 1'b0;
  logic          wren_in = 1'b0;
  logic          wrlayer_in = 1'b0;
  logic          rdlayer;
  logic [4:0]    rdaddress;
  logic          rden_LLR;
  logic          rden_E;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [IB-1:0] iter_count;

  siso_layer_sched #(
    .LAYERS(LAYERS), .ADDRWIDTH(5), .ADDRDEPTH(DEPTH),
    .ITERBITS(IB), .TOBITS(6), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
    .early_stop(early_stop), .wren_in(wren_in),
    .wrlayer_in(wrlayer_in), .rdlayer(rdlayer),
    .rdaddress(rdaddress), .rden_LLR(rden_LLR), .rden_E(rden_E),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic [4:0] a;
    logic       e;
    int         c;
  } rd_t;

  rd_t  rq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   mode = 0;
  int   es = 0;
  bit   mid = 0;
  bit   mid_done = 0;
  bit   dropped = 0;
  logic dv[DLY];
  logic dl[DLY];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then drive next inputs.
  task automatic tick();
    logic v;
    logic l;
    rd_t  r;
    @(posedge clk);
    #1;
    cyc++;
    if (rden_LLR) begin
      r.l = rdlayer;
      r.a = rdaddress;
      r.e = rden_E;
      r.c = cyc;
      rq.push_back(r);
    end else if (rden_E) begin
      chk("rden_E_without_LLR", 32'(rden_E), 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    v = dv[DLY-1];
    l = dl[DLY-1];
    for (int i = DLY - 1; i > 0; i--) begin
      dv[i] = dv[i-1];
      dl[i] = dl[i-1];
    end
    dv[0] = rden_LLR;
    dl[0] = rdlayer;
    if (v && l == 1'b0 && mode == 1 && !dropped) begin
      v = 1'b0;
      dropped = 1'b1;
    end
    if (v && l == 1'b0 && mode == 2) l = 1'b1;
    wren_in = v;
    wrlayer_in = l;
    start = mid && !mid_done && rq.size() == 5;
    if (start) mid_done = 1'b1;
    if (es != 0 && rq.size() == LAYERS * DEPTH * es) early_stop = 1'b1;
  endtask

  task automatic begin_job(input int mi, input int e, input int md,
                           input bit m);
    rq.delete();
    done_cnt = 0;
    mode = md;
    es = e;
    mid = m;
    mid_done = 1'b0;
    dropped = 1'b0;
    early_stop = 1'b0;
    for (int i = 0; i < DLY; i++) begin
      dv[i] = 1'b0;
      dl[i] = 1'b0;
    end
    wren_in = 1'b0;
    max_iter = IB'(mi);
    start = 1'b1;
    tick();
  endtask

  task automatic run_job(input string tag, input int mi, input int e,
                         input int md, input bit m);
    int lim;
    int iters;
    int nrd;
    int n;
    bit to;
    lim = (mi == 0) ? 1 : mi;
    iters = (e != 0 && e < lim) ? e : lim;
    to = (md != 0);
    nrd = to ? DEPTH : iters * LAYERS * DEPTH;
    begin_job(mi, e, md, m);
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_to_cleared"}, 32'(timeout_err), 32'd0);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) tick();
    chk({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    repeat (6) tick();
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({tag, "_reads"}, 32'(rq.size()), 32'(nrd));
    chk({tag, "_iter"}, 32'(iter_count), to ? 32'd0 : 32'(iters));
    chk({tag, "_timeout"}, 32'(timeout_err), 32'(to));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    n = (rq.size() < nrd) ? rq.size() : nrd;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_rd"}, {rq[i].l, rq[i].a, rq[i].e},
          {1'((i / DEPTH) % LAYERS), 5'(i % DEPTH),
           1'(i / (LAYERS * DEPTH) != 0)});
      if (i % DEPTH != 0)
        chk({tag, "_contig"}, 32'(rq[i].c - rq[i-1].c), 32'd1);
      else if (i > 0)
        chk({tag, "_gap"}, 32'(rq[i].c - rq[i-1].c > 1), 32'd1);
    end
    if (to && rq.size() == DEPTH)
      chk({tag, "_to_cycles"}, 32'(done_cyc - rq[DEPTH-1].c), 32'(TO));
  endtask

  initial begin
    int mi;
    int e;
    rst = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {rdlayer, rdaddress, rden_LLR, rden_E, busy, done,
         timeout_err, iter_count}, '0);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    chk("reset_idle", {busy, rden_LLR, 32'(done_cnt)}, '0);

    run_job("single", 1, 0, 0, 0);
    run_job("three", 3, 0, 0, 0);
    run_job("early", 10, 1, 0, 0);
    run_job("timeout", 1, 0, 1, 0);
    run_job("clear", 1, 0, 0, 0);
    run_job("wrongtag", 2, 0, 2, 0);
    run_job("midstart", 2, 0, 0, 1);
    run_job("zero", 0, 0, 0, 0);

    begin_job(2, 0, 0, 0);
    for (int k = 0; k < 500 && rq.size() < DEPTH; k++) tick();
    repeat (3) tick();
    chk("drain_busy", {busy, rden_LLR}, 2'b10);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("drain_rst", {busy, done, rden_LLR, iter_count}, '0);
    repeat (20) tick();
    chk("drain_rst_nodone", 32'(done_cnt), 32'd0);
    chk("drain_rst_noreads", 32'(rq.size()), 32'(DEPTH));

    for (int r = 0; r < 4; r++) begin
      mi = $urandom_range(0, 4);
      e = $urandom_range(0, 4);
      run_job("rand", mi, e, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/siso_layer_sched.md
Name: siso_layer_sched

Overview:
- Upstream controller for the pipelined SISO row unit: generates the registered read stream (rdlayer, rdaddress, rden_LLR, rden_E) that feeds the row unit's input registers.
- Sequences all addresses of each layer, then stalls until that layer's writebacks have retired. This preserves the layered-decoding data dependency.
- Counts decoding iterations and stops on the iteration limit, on the early-stop flag, or on a drain watchdog timeout.

Parameters:
LAYERS, 2, number of layers per iteration; legal values 1..2 because the layer index is 1 bit.
ADDRWIDTH, 5, width of the per-layer address.
ADDRDEPTH, 20, addresses per layer; issued as 0..ADDRDEPTH-1.
ITERBITS, 5, width of the iteration counter and max_iter.
TOBITS, 6, width of the drain watchdog counter.
DRAIN_TIMEOUT, 40, maximum DRAIN cycles before abort.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  single-cycle pulse that begins decoding; ignored unless in IDLE
max_iter  in  ITERBITS  iteration limit, sampled on start; 0 is treated as 1
early_stop  in  1  syndrome-satisfied flag, sampled only in CHECK
wren_in  in  1  row-unit writeback enable
wrlayer_in  in  1  row-unit writeback layer
rdlayer  out  1  layer of the current read
rdaddress  out  ADDRWIDTH  current read address
rden_LLR  out  1  LLR read enable
rden_E  out  1  E-memory read enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
timeout_err  out  1  sticky abort flag; cleared by the next accepted start
iter_count  out  ITERBITS  completed iterations; holds after DONE

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. All outputs are 0, including iter_count and timeout_err. Internal address, writeback and watchdog counters are 0. Reset mid-operation aborts immediately with no done pulse.
- All outputs are registered. start sampled at edge T gives the first rden_LLR=1 at edge T+1.
- IDLE:
  - Read enables are 0.
  - On start: latch max(max_iter,1), clear iter_count and timeout_err, set layer=0 and addr=0, go to ISSUE.
- ISSUE:
  - Every cycle drive rden_LLR=1, rdlayer=layer, rdaddress=addr.
  - rden_E=1 only when iter_count!=0. In iteration 0 the E memory holds no valid data.
  - addr increments each cycle. After issuing ADDRDEPTH-1, go to DRAIN; the read enables are 0 on the following cycle. A layer therefore produces exactly ADDRDEPTH back-to-back reads.
- Writeback counter (wb_cnt):
  - Increments on wren_in=1 && wrlayer_in==layer, in both ISSUE and DRAIN. Writebacks start before ISSUE ends because the pipeline is shorter than ADDRDEPTH.
  - Cleared when a new layer enters ISSUE.
  - Writebacks with a mismatched layer, or any writeback in IDLE, CHECK or DONE, are ignored.
- DRAIN:
  - Read enables are 0; the watchdog increments each cycle.
  - When wb_cnt==ADDRDEPTH, checked on the updated count so a writeback in the same cycle counts:
    - if layer<LAYERS-1: layer+1, addr=0, watchdog=0, go to ISSUE;
    - otherwise go to CHECK.
  - If the watchdog reaches DRAIN_TIMEOUT first: set timeout_err=1 and go to DONE.
- CHECK (1 cycle):
  - iter_count+1.
  - If early_stop=1 or the new count equals the latched limit, go to DONE.
  - Otherwise layer=0, addr=0, go to ISSUE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. iter_count and timeout_err hold until the next start.
- start asserted in any non-IDLE state has no effect.
- Minimum per-layer period is ADDRDEPTH + drain latency; there is no overlap between layers.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> all outputs 0, busy=0. Release with start=0 -> state stays IDLE.
- Single iteration: max_iter=1; model the writeback as rden_LLR delayed 13 cycles, carrying its layer.
  - Reads: 20 reads with rdlayer=0 and addresses 0..19, then a gap, then 20 reads with rdlayer=1.
  - rden_E=0 throughout.
  - done pulses once, iter_count=1.
- Three iterations: max_iter=3, same writeback model -> rden_E=0 in iteration 0 and 1 in iterations 1-2; 120 reads in total; done with iter_count=3.
- Early stop: max_iter=10, early_stop=1 during the first CHECK -> done follows that CHECK, iter_count=1, and no further reads are issued.
- Timeout: only 19 writebacks returned for layer 0 -> after 40 DRAIN cycles timeout_err=1, done pulses, no layer-1 reads. The next start clears timeout_err.
- Robustness:
  - Writebacks tagged with the wrong layer are not counted; the block stays in DRAIN.
  - start pulsed mid-ISSUE changes nothing.
  - max_iter=0 runs exactly 1 iteration.
  - rst=0 during DRAIN returns to IDLE with no done pulse.
